// File: rtl/mux_sched_pkg.sv
// Shared constants and the FIFO entry layout for the mux4 scheduler.
package mux_sched_pkg;
  localparam int NREQ           = 4;
  localparam int SRC_W          = 2;
  localparam int DATA_W         = 32;
  localparam int FIFO_DEPTH_MIN = 3;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/mux4.sv
// Existing registered 4:1 mux datapath; result follows sel one cycle later.
module mux4 (
  input  logic        clock,
  input  logic        aclr,
  input  logic [1:0]  sel,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  output logic [31:0] result
);
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      result <= '0;
    end else begin
      case (sel)
        2'd0:    result <= data0;
        2'd1:    result <= data1;
        2'd2:    result <= data2;
        default: result <= data3;
      endcase
    end
  end
endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: round-robin after last_grant,
// or fixed priority with index 0 highest.
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] last_grant,
  input  logic       prio_mode,
  output logic       any,
  output logic [1:0] winner
);
  logic [1:0] idx;

  always_comb begin
    any    = |eligible;
    winner = 2'd0;
    idx    = 2'd0;
    if (prio_mode) begin
      for (int i = 3; i >= 0; i--) begin
        if (eligible[i]) winner = 2'(i);
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest eligible one wins.
      for (int k = 4; k >= 1; k--) begin
        idx = last_grant + 2'(k);
        if (eligible[idx]) winner = idx;
      end
    end
  end
endmodule

// File: rtl/mux4_sched.sv
// Round-robin/fixed-priority scheduler sharing one registered mux4 among four
// producers, with a credit-checked output FIFO tagged by source index.
module mux4_sched
  import mux_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 3
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  input  logic [31:0] req_data2,
  input  logic [31:0] req_data3,
  output logic [3:0]  req_ready,
  input  logic [3:0]  req_mask,
  input  logic        prio_mode,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [1:0]  out_src,
  input  logic        out_ready,
  output logic [1:0]  fifo_count
);
  localparam logic [1:0] DEPTH_L  = 2'(FIFO_DEPTH);
  localparam logic [1:0] LAST_PTR = 2'(FIFO_DEPTH - 1);

  logic        run_q, any, credit, grant, s1_valid, fifo_wr, fifo_pop;
  logic [1:0]  winner, sel, sel_q, last_grant, s1_src;
  logic [1:0]  wr_ptr, rd_ptr, count;
  logic [DATA_W-1:0] result;
  fifo_entry_t mem [FIFO_DEPTH];
  fifo_entry_t head;

  rr_pick4 u_pick (
    .eligible   (req_valid & req_mask),
    .last_grant (last_grant),
    .prio_mode  (prio_mode),
    .any        (any),
    .winner     (winner)
  );

  // Credit ignores a same-cycle pop so req_ready never depends on out_ready.
  assign credit    = ({1'b0, count} + {2'b0, s1_valid}) < {1'b0, DEPTH_L};
  assign grant     = run_q & any & credit;
  assign sel       = grant ? winner : sel_q;
  assign req_ready = grant ? (4'b0001 << winner) : 4'b0000;

  mux4 u_mux (
    .clock  (clock),
    .aclr   (aclr),
    .sel    (sel),
    .data0  (req_data0),
    .data1  (req_data1),
    .data2  (req_data2),
    .data3  (req_data3),
    .result (result)
  );

  // run_q holds off grants until the first edge after aclr is released.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      run_q      <= 1'b0;
      last_grant <= 2'd3;
      sel_q      <= 2'd0;
      s1_valid   <= 1'b0;
      s1_src     <= 2'd0;
    end else begin
      run_q    <= 1'b1;
      sel_q    <= sel;
      s1_valid <= grant;
      if (grant) begin
        last_grant <= winner;
        s1_src     <= winner;
      end
    end
  end

  assign fifo_wr  = s1_valid;
  assign fifo_pop = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (fifo_wr) mem[wr_ptr] <= '{src: s1_src, data: result};
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (fifo_wr)  wr_ptr <= (wr_ptr == LAST_PTR) ? 2'd0 : wr_ptr + 2'd1;
      if (fifo_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? 2'd0 : rd_ptr + 2'd1;
      case ({fifo_wr, fifo_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head       = mem[rd_ptr];
  assign out_valid  = (count != 2'd0);
  assign out_data   = out_valid ? head.data : '0;
  assign out_src    = out_valid ? head.src : '0;
  assign fifo_count = count;

  overflow_chk: assert property (@(posedge clock) disable iff (aclr)
    !(fifo_wr && count == DEPTH_L));
endmodule
